// File: rtl/mod_accumulator.sv
// Framed modular accumulator: sums residue beats mod m and reports one
// result, beat count and error flag per frame over a valid/ready handshake.
module mod_accumulator #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] count,
    output logic             error,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_live;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_count;
    logic             r_error;

    logic             w_accept;
    logic             w_first;
    logic [WIDTH-1:0] w_mod;
    logic [WIDTH-1:0] w_acc_base;
    logic [WIDTH-1:0] w_cnt_base;
    logic             w_err_base;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_sum_red;
    logic             w_bad;
    logic [WIDTH-1:0] w_acc_new;
    logic [WIDTH-1:0] w_cnt_new;
    logic             w_err_new;

    assign w_accept = in_valid && in_ready;

    // The first beat of a frame starts from a clean slate and uses the live modulus.
    assign w_first    = (r_state == S_IDLE);
    assign w_mod      = w_first ? m : r_m;
    assign w_acc_base = w_first ? '0 : r_acc;
    assign w_cnt_base = w_first ? '0 : r_count;
    assign w_err_base = w_first ? 1'b0 : r_error;

    // One spare bit holds acc + in_data, which can reach 2*(2^WIDTH-1).
    assign w_sum     = {1'b0, w_acc_base} + {1'b0, in_data};
    assign w_sum_red = (w_sum >= {1'b0, w_mod}) ? (w_sum - {1'b0, w_mod}) : w_sum;
    assign w_bad     = (w_mod == '0) || (in_data >= w_mod);
    assign w_acc_new = w_bad ? w_acc_base : w_sum_red[WIDTH-1:0];
    assign w_cnt_new = (&w_cnt_base) ? w_cnt_base : (w_cnt_base + WIDTH'(1));
    assign w_err_new = w_err_base | w_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = in_last ? S_OUT : S_ACC;
            S_ACC:  if (w_accept && in_last) w_state_next = S_OUT;
            S_OUT:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = r_live && (r_state != S_OUT);
        out_valid = (r_state == S_OUT);
    end

    // Holds in_ready low until the first edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_m     <= '0;
            r_count <= '0;
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_m     <= w_mod;
            r_acc   <= w_acc_new;
            r_count <= w_cnt_new;
            r_error <= w_err_new;
        end
    end

    assign result = r_acc;
    assign count  = r_count;
    assign error  = r_error;

endmodule
